inst_rom_loader: RTL



---
 rtl/inst_rom_loader_pkg.sv | 28 ++
 rtl/inst_ram_1w1r.sv | 38 +++
 rtl/inst_rom_loader.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/inst_rom_loader_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : inst_rom_loader_pkg
//  Purpose  : Shared defines for the openmips instruction-memory loader.
//             - InstMemNumLog2   : default log2 word depth of the array
//             - ZeroWord         : all-zero word, also the NOP fetch value
//             - InstBus/InstAddrBus widths and matching types
//             - load FSM state encodings (LdLoad / LdRun / LdErr)
//  Revision : 1.0 - initial release
// ============================================================================
package inst_rom_loader_pkg;

   localparam int          InstMemNumLog2 = 10;
   localparam int          InstBusW       = 32;
   localparam int          InstAddrBusW   = 32;
   localparam logic [31:0] ZeroWord       = 32'h0000_0000;

   typedef logic [InstBusW-1:0]     inst_bus_t;
   typedef logic [InstAddrBusW-1:0] inst_addr_bus_t;

   typedef enum logic [1:0] {
      LdLoad = 2'd0,
      LdRun  = 2'd1,
      LdErr  = 2'd2
   } ld_state_e;

endpackage : inst_rom_loader_pkg
`default_nettype wire

// File: rtl/inst_ram_1w1r.sv
`default_nettype none
// ============================================================================
//  Module   : inst_ram_1w1r
//  Purpose  : 2^ADDR_W x 32-bit storage, one synchronous write port and one
//             asynchronous (combinational) read port. Contents are not reset.
//  Ports    : clk      - write clock
//             we_i     - write enable
//             waddr_i  - write word address
//             wdata_i  - write data
//             raddr_i  - read word address
//             rdata_o  - read data (same-cycle)
//  Revision : 1.0 - initial release
// ============================================================================
module inst_ram_1w1r
   import inst_rom_loader_pkg::*;
#(
   parameter int ADDR_W = InstMemNumLog2
) (
   input  logic              clk,
   input  logic              we_i,
   input  logic [ADDR_W-1:0] waddr_i,
   input  logic [31:0]       wdata_i,
   input  logic [ADDR_W-1:0] raddr_i,
   output logic [31:0]       rdata_o
);

   logic [31:0] mem [0:(1<<ADDR_W)-1];

   always_ff @(posedge clk) begin
      if (we_i) begin
         mem[waddr_i] <= wdata_i;
      end
   end

   assign rdata_o = mem[raddr_i];

endmodule : inst_ram_1w1r
`default_nettype wire

// File: rtl/inst_rom_loader.sv
`default_nettype none
// ============================================================================
//  Module   : inst_rom_loader
//  Purpose  : Instruction memory for the openmips fetch port. A byte-stream
//             load port fills the array (big-endian packing) while the core
//             is held in reset; after a clean load the core is released and
//             fetches are served with zero-cycle latency.
//  Ports    : clk, rst        - clock, async active-high reset
//             rom_ce_i        - fetch enable from core
//             rom_addr_i      - fetch byte address from core
//             rom_data_o      - fetched instruction (0 = NOP when not served)
//             ld_valid_i      - load byte present
//             ld_byte_i       - load byte
//             ld_last_i       - marks final byte of the image
//             ld_ready_o      - load bytes accepted
//             cpu_rst_o       - core reset, high until a clean load completes
//             load_done_o     - high in RUN
//             ld_err_o        - sticky load error
//  Revision : 1.0 - initial release
// ============================================================================
module inst_rom_loader
   import inst_rom_loader_pkg::*;
#(
   parameter int ADDR_W = InstMemNumLog2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        rom_ce_i,
   input  logic [31:0] rom_addr_i,
   output logic [31:0] rom_data_o,
   input  logic        ld_valid_i,
   input  logic [7:0]  ld_byte_i,
   input  logic        ld_last_i,
   output logic        ld_ready_o,
   output logic        cpu_rst_o,
   output logic        load_done_o,
   output logic        ld_err_o
);

   localparam logic [ADDR_W-1:0] PTR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
   localparam logic [ADDR_W:0]   CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};

   ld_state_e         state_q, state_d;
   logic              ld_ready_q, ld_ready_d;
   logic [1:0]        byte_cnt_q, byte_cnt_d;
   logic [ADDR_W-1:0] ptr_q, ptr_d;
   logic [ADDR_W:0]   count_q, count_d;
   logic [31:0]       word_q, word_d;

   logic              we;
   logic [31:0]       wdata;
   logic [ADDR_W-1:0] rd_idx;
   logic [31:0]       ram_rdata;
   logic              rd_hit;

   // ---------------------------------------------------------------
   // Load FSM, byte packer and counters
   // ---------------------------------------------------------------
   always_comb begin
      state_d    = state_q;
      byte_cnt_d = byte_cnt_q;
      ptr_d      = ptr_q;
      count_d    = count_q;
      word_d     = word_q;
      we         = 1'b0;
      // Byte n of a word lands at bits [31-8n -: 8]; bytes not yet received
      // are still zero in word_q, which gives the padding on an early last.
      wdata      = word_q | ({24'h0, ld_byte_i} << {~byte_cnt_q, 3'b000});

      // ld_ready_q is only ever high in LOAD, so it alone qualifies transfers.
      if (ld_valid_i && ld_ready_q) begin
         if (ld_last_i || (byte_cnt_q == 2'd3)) begin
            we         = 1'b1;
            word_d     = ZeroWord;
            byte_cnt_d = 2'd0;
            ptr_d      = ptr_q + PTR_ONE;
            count_d    = count_q + CNT_ONE;
            if (ld_last_i) begin
               state_d = (byte_cnt_q == 2'd3) ? LdRun : LdErr;
            end else if (ptr_q == {ADDR_W{1'b1}}) begin
               state_d = LdErr;   // array full and image not finished
            end
         end else begin
            word_d     = wdata;
            byte_cnt_d = byte_cnt_q + 2'd1;
         end
      end

      // Ready is registered so it stays low through the first cycle after
      // reset release, then follows LOAD.
      ld_ready_d = (state_d == LdLoad);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= LdLoad;
         ld_ready_q <= 1'b0;
         byte_cnt_q <= 2'd0;
         ptr_q      <= '0;
         count_q    <= '0;
         word_q     <= ZeroWord;
      end else begin
         state_q    <= state_d;
         ld_ready_q <= ld_ready_d;
         byte_cnt_q <= byte_cnt_d;
         ptr_q      <= ptr_d;
         count_q    <= count_d;
         word_q     <= word_d;
      end
   end

   // ---------------------------------------------------------------
   // Storage
   // ---------------------------------------------------------------
   assign rd_idx = rom_addr_i[ADDR_W+1:2];

   inst_ram_1w1r #(
      .ADDR_W (ADDR_W)
   ) u_ram (
      .clk     (clk),
      .we_i    (we),
      .waddr_i (ptr_q),
      .wdata_i (wdata),
      .raddr_i (rd_idx),
      .rdata_o (ram_rdata)
   );

   // ---------------------------------------------------------------
   // Fetch path: only loaded words inside the array are served in RUN;
   // stale contents beyond the loaded count read as NOP.
   // ---------------------------------------------------------------
   assign rd_hit = (state_q == LdRun) && rom_ce_i
                && ((rom_addr_i >> (ADDR_W + 2)) == ZeroWord)
                && ({1'b0, rd_idx} < count_q);

   assign rom_data_o  = rd_hit ? ram_rdata : ZeroWord;
   assign ld_ready_o  = ld_ready_q;
   assign cpu_rst_o   = (state_q != LdRun);
   assign load_done_o = (state_q == LdRun);
   assign ld_err_o    = (state_q == LdErr);

endmodule : inst_rom_loader
`default_nettype wire
